// File: rtl/seq_mult_param.sv
// Parametrised shift-add sequential multiplier with signed/unsigned mode and start/busy/done handshake.
// Optional build macro SEQ_MULT_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier is zero.
module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [CW-1:0]      r_count;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_sign;
    logic [2*WIDTH-1:0] w_acc_add;
    logic               w_last_run;

    // Negating the most-negative value yields 2^(WIDTH-1), which still fits as an unsigned magnitude.
    always_comb begin
        w_mag_a = (signed_mode && A[WIDTH-1]) ? (-A) : A;
        w_mag_b = (signed_mode && B[WIDTH-1]) ? (-B) : B;
        w_sign  = signed_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
    end

    always_comb begin
        w_acc_add = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`ifdef SEQ_MULT_EARLY_TERM_EN
        w_last_run = (r_mplier[WIDTH-1:1] == '0) || (r_count == CW'(WIDTH - 1));
`else
        w_last_run = (r_count == CW'(WIDTH - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last_run) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_count  <= '0;
            product  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_neg    <= w_sign;
                        r_count  <= '0;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_add;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                end
                S_FIX: begin
                    product <= r_neg ? (-r_acc) : r_acc;
                end
                default: ;
            endcase
            // Registered so busy covers RUN+FIX and drops in the done cycle.
            busy <= (w_state_nxt != S_IDLE);
            done <= (r_state == S_FIX);
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: vector table, hand-written corner sequences and random ops
// against an arithmetic reference model (latency model follows SEQ_MULT_EARLY_TERM_EN if defined).
module tb_seq_mult_param;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    seq_mult_param #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .signed_mode(signed_mode),
        .A(A),
        .B(B),
        .product(product),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           sm;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        longint x, y, p;
        x = sm ? longint'($signed(a)) : longint'(a);
        y = sm ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[2*W-1:0];
    endfunction

    // Edges from the accept edge to the edge that raises done.
    function automatic int ref_lat(input logic [W-1:0] b, input logic sm);
        longint y;
        int n;
        y = sm ? longint'($signed(b)) : longint'(b);
        if (y < 0) y = -y;
`ifdef SEQ_MULT_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < W; i++) if (y[i]) n = i + 1;
`else
        n = W;
`endif
        return n + 1;
    endfunction

    // Launch one op, scramble inputs after accept, wait for done (bounded).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                          output int lat, output int busy_cnt, output logic timed_out);
        @(negedge clk);
        A = a; B = b; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); signed_mode = 1'($urandom);
        lat = 0; busy_cnt = 0; timed_out = 1'b0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) timed_out = 1'b1;
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL %s: done timeout got none expected pulse", name);
        end
    endtask

    initial begin
        int lat, bc, pulses, t1, t2;
        logic to;

        vecs[0] = '{8'd15,  8'd10,  1'b0, 16'd150};
        vecs[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01};
        vecs[2] = '{8'hF9,  8'd6,   1'b1, 16'hFFD6};
        vecs[3] = '{8'h80,  8'h80,  1'b1, 16'h4000};
        vecs[4] = '{8'h80,  8'h01,  1'b1, 16'hFF80};
        vecs[5] = '{8'h00,  8'h00,  1'b0, 16'h0000};
        vecs[6] = '{8'h80,  8'h80,  1'b0, 16'h4000};
        vecs[7] = '{8'h7F,  8'h81,  1'b1, 16'hC0FF};
        vecs[8] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
        vecs[9] = '{8'h23,  8'h01,  1'b0, 16'h0023};

        reset = 1'b1; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_product", product, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sm, lat, bc, to);
            check($sformatf("vec%0d_timeout", i), to, 0);
            check($sformatf("vec%0d_product", i), product, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, ref_lat(vecs[i].b, vecs[i].sm));
            check($sformatf("vec%0d_busy_cycles", i), bc, ref_lat(vecs[i].b, vecs[i].sm));
            check($sformatf("vec%0d_busy_in_done", i), busy, 0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_single", i), done, 0);
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        A = 8'd3; B = 8'd4; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        A = 8'd9; B = 8'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_ignore", lat);
        check("busy_ignore_product", product, 12);
        A = 8'd5; B = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_cycle_accept_busy", busy, 1);
        check("done_cycle_hold_product", product, 12);
        wait_done("done_cycle_accept", lat);
        check("done_cycle_accept_product", product, 25);
        check("done_cycle_accept_latency", lat, ref_lat(8'd5, 1'b0));

        // Reset 4 cycles into RUN aborts without a done pulse.
        @(negedge clk);
        A = 8'd200; B = 8'd100; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_product", product, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run_op(8'd2, 8'd3, 1'b0, lat, bc, to);
        check("after_abort_product", product, 6);

        // Start held high: back-to-back ops, period = latency + 1.
        @(negedge clk);
        A = 8'd6; B = 8'd7; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        wait_done("b2b_first", t1);
        check("b2b_first_product", product, 42);
        @(posedge clk); #1;
        wait_done("b2b_second", t2);
        start = 1'b0;
        check("b2b_period", t2 + 1, ref_lat(8'd7, 1'b0) + 1);
        check("b2b_second_product", product, 42);
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic rs;
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            if (i % 8 == 0) rb = W'($urandom_range(0, 3));
            run_op(ra, rb, rs, lat, bc, to);
            check($sformatf("rand%0d_product", i), product, ref_prod(ra, rb, rs));
            check($sformatf("rand%0d_latency", i), lat, ref_lat(rb, rs));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
